gate_unit_arbiter: RTL and testbench

//   Shares one bitwise logic-gate unit (AND/OR/NOT/NOR/XOR) between NUM_REQ requesters.

---
 rtl/gate_unit_arbiter.sv | 147 ++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin sharing of one bitwise gate unit
// (AND/OR/NOT/NOR/XOR) between NUM_REQ requesters. One transaction is in
// flight at a time; the result returns on a single channel tagged with the
// requester ID.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; combinational one-hot grant; latch winner's operands
// EXEC  | evaluate latched operands, register result, error flag and id
// RESP  | present response; hold it until rsp_ready
module gate_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_last_id;
    logic [ID_W-1:0]  r_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_found;
    logic [ID_W-1:0]  w_win_id;
    logic [ID_W-1:0]  w_idx;
    int               w_sum;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_gate;
    logic             w_err;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        w_sum    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = (int'(r_last_id) + k) % NUM_REQ;
            w_idx = ID_W'(w_sum);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_id == ID_W'(i)) begin
                w_sel_op = req_op[3*i +: 3];
                w_sel_a  = req_a[WIDTH*i +: WIDTH];
                w_sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Shared gate datapath on the latched operands.
    always_comb begin
        w_gate = '0;
        w_err  = 1'b0;
        case (r_op)
            3'b000:  w_gate = r_a & r_b;
            3'b001:  w_gate = r_a | r_b;
            3'b010:  w_gate = ~r_a;
            3'b011:  w_gate = ~(r_a | r_b);
            3'b100:  w_gate = r_a ^ r_b;
            default: w_err  = 1'b1;
        endcase
    end

    // Grant is only offered in IDLE, and forced low while reset is asserted.
    assign req_ready = (r_state == S_IDLE && w_found && !rst)
                       ? (NUM_REQ'(1) << w_win_id) : '0;

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last_id <= ID_W'(NUM_REQ - 1);
            r_id      <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op      <= w_sel_op;
                        r_a       <= w_sel_a;
                        r_b       <= w_sel_b;
                        r_id      <= w_win_id;
                        r_last_id <= w_win_id;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= w_gate;
                    rsp_err   <= w_err;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter: stimulus pushes hand-computed
// responses into a queue, a monitor pops and compares on each accepted
// response.
module tb_gate_unit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WIDTH   = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_BAD = 3'b111;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        logic             err;
    } rsp_t;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [3*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_err;
    logic                     rsp_ready;

    rsp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    gate_unit_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    task automatic set_op(input int i, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_op[3*i +: 3]         = op;
        req_a[WIDTH*i +: WIDTH]  = a;
        req_b[WIDTH*i +: WIDTH]  = b;
    endtask

    task automatic push(input int id, input logic [WIDTH-1:0] d, input logic e);
        rsp_t r;
        r.id   = ID_W'(id);
        r.data = d;
        r.err  = e;
        q.push_back(r);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Waits (bounded) at negedges for a nonzero grant; returns cycles waited.
    task automatic wait_grant(output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) got = 1'b1;
        end
        if (!got) fail_now("grant_wait");
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) done = 1'b1;
        end
        if (!done) fail_now("rsp_wait");
        @(posedge clk);
    endtask

    // Single transaction with exact latency checks.
    task automatic do_txn(input logic [3:0] mask, input int id,
                          input logic [WIDTH-1:0] d, input logic e);
        bit got;
        int cyc;
        @(posedge clk); #1 req_valid = mask;
        wait_grant(got, cyc);
        if (!got) begin
            req_valid = '0;
            return;
        end
        chk("grant", 32'(req_ready), 32'(NUM_REQ'(1) << id));
        push(id, d, e);
        @(negedge clk);
        chk("exec_ready_low", 32'(req_ready), 32'h0);
        chk("exec_valid_low", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("resp_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk);
    endtask

    // Monitor: compares every accepted response against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h, expected none", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = q.pop_front();
                chk("rsp_id",   32'(rsp_id),   32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_err",  32'(rsp_err),  32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]       sw_op  [6];
        logic [WIDTH-1:0] sw_dat [6];
        logic             sw_err [6];
        int               order  [5];
        logic [WIDTH-1:0] odat   [5];
        bit               got;
        int               cyc;

        sw_op  = '{OP_AND, OP_OR, OP_NOT, OP_NOR, OP_XOR, OP_BAD};
        sw_dat = '{8'h05, 8'hAF, 8'h5A, 8'h50, 8'hAA, 8'h00};
        sw_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        order  = '{0, 1, 2, 3, 0};
        odat   = '{8'h30, 8'hFF, 8'hAA, 8'hFE, 8'h30};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_ready",    32'(req_ready), 32'h0);
        chk("rst_valid",    32'(rsp_valid), 32'h0);
        chk("rst_id",       32'(rsp_id),    32'h0);
        chk("rst_data",     32'(rsp_data),  32'h0);
        chk("rst_err",      32'(rsp_err),   32'h0);
        req_valid = '0;
        @(posedge clk); #1 rst = 1'b0;

        // Single request
        set_op(0, OP_AND, 8'hF0, 8'h3C);
        do_txn(4'b0001, 0, 8'h30, 1'b0);

        // Op sweep on requester 2
        for (int k = 0; k < 6; k++) begin
            set_op(2, sw_op[k], 8'hA5, 8'h0F);
            do_txn(4'b0100, 2, sw_dat[k], sw_err[k]);
        end

        // Round-robin with all requesters held valid
        reset_dut();
        set_op(0, OP_AND, 8'hF0, 8'h3C);
        set_op(1, OP_OR,  8'hF0, 8'h0F);
        set_op(2, OP_NOT, 8'h55, 8'h00);
        set_op(3, OP_NOR, 8'h00, 8'h01);
        @(posedge clk); #1 req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_grant(got, cyc);
            if (got) begin
                chk("rr_grant", 32'(req_ready), 32'(NUM_REQ'(1) << order[g]));
                if (g > 0) chk("rr_spacing", 32'(cyc), 32'd3);
                push(order[g], odat[g], 1'b0);
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Backpressure
        rsp_ready = 1'b0;
        set_op(1, OP_XOR, 8'h12, 8'h34);
        set_op(2, OP_AND, 8'hFF, 8'h81);
        @(posedge clk); #1 req_valid = 4'b0010;
        wait_grant(got, cyc);
        chk("bp_grant", 32'(req_ready), 32'h2);
        push(1, 8'h26, 1'b0);
        @(posedge clk); #1 req_valid = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) fail_now("bp_rsp_wait");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_data",  32'(rsp_data),  32'h26);
            chk("bp_id",    32'(rsp_id),    32'h1);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", 32'(req_ready), 32'h4);
        push(2, 8'h81, 1'b0);
        @(posedge clk); #1 req_valid = '0;
        wait_done();

        // Pointer wrap
        reset_dut();
        set_op(1, OP_OR,  8'h01, 8'h02);
        set_op(3, OP_NOT, 8'h0F, 8'h00);
        do_txn(4'b1010, 1, 8'h03, 1'b0);
        do_txn(4'b1000, 3, 8'hF0, 1'b0);
        do_txn(4'b1010, 1, 8'h03, 1'b0);

        // Reset in EXEC discards the transaction
        set_op(0, OP_AND, 8'hF0, 8'h3C);
        @(posedge clk); #1 req_valid = 4'hF;
        wait_grant(got, cyc);
        chk("r6_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("r6_async_valid", 32'(rsp_valid), 32'h0);
        chk("r6_async_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("r6_no_resp", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("r6_first_grant", 32'(req_ready), 32'h1);
        push(0, 8'h30, 1'b0);
        @(posedge clk); #1 req_valid = '0;
        wait_done();

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
